// File: rtl/trace_pkg.sv
// Shared types and constants for the register-file trace transmitter.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_REG
    } trace_state_t;

    localparam int          FRAME_WORDS     = 33;
    localparam logic [15:0] DEFAULT_HDR_TAG = 16'hC10C;
    localparam logic [4:0]  LAST_ADDR       = 5'(FRAME_WORDS - 2);

endpackage

// File: rtl/reg_trace_tx.sv
// Streams a tagged header followed by all 32 GPRs as a valid/ready frame,
// queueing one trigger while busy and counting the ones it has to drop.
module reg_trace_tx
    import trace_pkg::*;
#(
    parameter logic [15:0] HDR_TAG = DEFAULT_HDR_TAG,
    parameter int          DROP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    output logic [4:0]        rf_raddr,
    input  logic [31:0]       rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    trace_state_t state, state_next;

    logic [15:0] cycle;
    logic        pending, pending_next;
    logic [15:0] pend_cnt, pend_cnt_next;
    logic [15:0] hdr_cnt;
    logic        load_hdr, load_reg, go_idle, drop;
    logic        hs, final_hs;

    assign hs       = out_valid && out_ready;
    assign final_hs = hs && out_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // A trigger arriving on the final handshake never counts as a drop: it
    // either starts the next frame directly or replaces the consumed pending one.
    always_comb begin
        state_next    = state;
        load_hdr      = 1'b0;
        load_reg      = 1'b0;
        go_idle       = 1'b0;
        drop          = 1'b0;
        hdr_cnt       = cycle;
        pending_next  = pending;
        pend_cnt_next = pend_cnt;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    load_hdr   = 1'b1;
                    state_next = ST_HDR;
                end
            end
            ST_HDR, ST_REG: begin
                if (final_hs) begin
                    if (pending) begin
                        load_hdr     = 1'b1;
                        hdr_cnt      = pend_cnt;
                        state_next   = ST_HDR;
                        pending_next = trig;
                        if (trig) pend_cnt_next = cycle;
                    end else if (trig) begin
                        load_hdr   = 1'b1;
                        state_next = ST_HDR;
                    end else begin
                        go_idle    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else begin
                    if (hs) begin
                        load_reg   = 1'b1;
                        state_next = ST_REG;
                    end
                    if (trig) begin
                        if (!pending) begin
                            pending_next  = 1'b1;
                            pend_cnt_next = cycle;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle     <= '0;
            pending   <= 1'b0;
            pend_cnt  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            rf_raddr  <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            cycle    <= cycle + 16'd1;
            pending  <= pending_next;
            pend_cnt <= pend_cnt_next;
            if (load_hdr) begin
                out_data  <= {HDR_TAG, hdr_cnt};
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                rf_raddr  <= '0;
            end else if (load_reg) begin
                out_data <= rf_rdata;
                out_last <= (rf_raddr == LAST_ADDR);
                rf_raddr <= rf_raddr + 5'd1;
            end else if (go_idle) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != {DROP_W{1'b1}})
                    drop_cnt <= drop_cnt + {{(DROP_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_reg_trace_tx.sv
// Self-checking bench for reg_trace_tx: vector table for whole-frame scenarios
// plus hand-written reset-abort and drop-counter saturation sequences.
module tb_reg_trace_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        overflow;
    logic [7:0]  drop_cnt;

    logic [31:0] rf [32];
    assign rf_rdata = rf[rf_raddr];

    always #5 clk = ~clk;

    reg_trace_tx dut (
        .clk      (clk),
        .rst      (rst),
        .trig     (trig),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    typedef struct {
        int         t0, t1, t2;
        logic [2:0] accept;
        logic       toggle;
        int         firstCyc;
        int         endCyc;
        int         frames;
        logic       ovf;
        logic [7:0] drops;
    } vec_t;

    word_t       sb[$];
    vec_t        vecs[5];
    int          testsRun = 0;
    int          testsFailed = 0;
    int          curVec = -1;
    int          cyc;
    int          firstValid;
    int          lastHs;
    int          framesSeen;
    logic        stalled;
    logic [31:0] stallData;
    logic        stallLast;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL vec%0d %s: got %h expected %h", curVec, name, act, exp);
        end
    endtask

    task automatic pushFrame(input int c);
        word_t w;
        w.data = {16'hC10C, c[15:0]};
        w.last = 1'b0;
        sb.push_back(w);
        for (int k = 0; k < 32; k++) begin
            w.data = 32'(k) * 32'h11111111;
            w.last = (k == 31);
            sb.push_back(w);
        end
    endtask

    task automatic clearMonitor();
        sb.delete();
        firstValid = -1;
        lastHs     = -1;
        framesSeen = 0;
        stalled    = 1'b0;
    endtask

    task automatic checkOutput();
        word_t w;
        if (out_valid && firstValid < 0) firstValid = cyc;
        if (stalled) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", out_data, stallData);
            chk("stall_last", 32'(out_last), 32'(stallLast));
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL vec%0d unexpected_word: got %h expected none", curVec, out_data);
            end else begin
                w = sb.pop_front();
                chk("word_data", out_data, w.data);
                chk("word_last", 32'(out_last), 32'(w.last));
            end
            if (out_last) begin
                lastHs = cyc;
                framesSeen++;
            end
        end
        stalled   = out_valid && !out_ready;
        stallData = out_data;
        stallLast = out_last;
    endtask

    task automatic tick(input logic t, input logic r);
        trig      = t;
        out_ready = r;
        #4;
        checkOutput();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic resetDut();
        rst       = 1'b0;
        trig      = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        clearMonitor();
    endtask

    task automatic applyStimulus(input vec_t v);
        logic t, r;
        resetDut();
        for (int i = 0; i < 130; i++) begin
            t = (cyc == v.t0) || (cyc == v.t1) || (cyc == v.t2);
            if ((cyc == v.t0 && v.accept[0]) || (cyc == v.t1 && v.accept[1]) ||
                (cyc == v.t2 && v.accept[2]))
                pushFrame(cyc);
            r = v.toggle ? cyc[0] : 1'b1;
            tick(t, r);
        end
        trig = 1'b0;
        chk("first_valid_cycle", 32'(firstValid), 32'(v.firstCyc));
        chk("final_last_cycle", 32'(lastHs), 32'(v.endCyc));
        chk("frames_seen", 32'(framesSeen), 32'(v.frames));
        chk("overflow", 32'(overflow), 32'(v.ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(v.drops));
        chk("scoreboard_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = 32'(k) * 32'h11111111;

        // trig cycles, accepted mask, ready toggling, first valid, last handshake, frames, overflow, drops
        vecs[0] = '{5, -1, -1, 3'b001, 1'b0, 6, 38, 1, 1'b0, 8'd0};
        vecs[1] = '{5, -1, -1, 3'b001, 1'b1, 6, 71, 1, 1'b0, 8'd0};
        vecs[2] = '{5, 10, -1, 3'b011, 1'b0, 6, 71, 2, 1'b0, 8'd0};
        vecs[3] = '{5, 10, 12, 3'b011, 1'b0, 6, 71, 2, 1'b1, 8'd1};
        vecs[4] = '{5, 10, 38, 3'b111, 1'b0, 6, 104, 3, 1'b0, 8'd0};

        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_rf_raddr", 32'(rf_raddr), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

        for (int v = 0; v < 5; v++) begin
            curVec = v;
            applyStimulus(vecs[v]);
        end

        // Reset during word 20 aborts the frame; the cycle count restarts.
        curVec = 5;
        resetDut();
        while (cyc < 26) begin
            if (cyc == 5) pushFrame(cyc);
            tick(cyc == 5 || cyc == 7 || cyc == 9, 1'b1);
        end
        chk("pre_reset_overflow", 32'(overflow), 32'd1);
        chk("pre_reset_frames", 32'(framesSeen), 32'd0);
        #3 rst = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_last", 32'(out_last), 32'd0);
        chk("abort_out_data", out_data, 32'd0);
        chk("abort_rf_raddr", 32'(rf_raddr), 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        chk("abort_drop_cnt", 32'(drop_cnt), 32'd0);
        trig = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        clearMonitor();
        for (int i = 0; i < 50; i++) begin
            if (cyc == 3) pushFrame(cyc);
            tick(cyc == 3, 1'b1);
        end
        chk("restart_first_valid", 32'(firstValid), 32'd4);
        chk("restart_last_cycle", 32'(lastHs), 32'd36);
        chk("restart_frames", 32'(framesSeen), 32'd1);
        chk("restart_scoreboard_left", 32'(sb.size()), 32'd0);

        // Sink never ready, trigger held high: drop counter climbs then saturates.
        curVec = 6;
        resetDut();
        pushFrame(0);
        for (int i = 0; i < 100; i++) tick(1'b1, 1'b0);
        chk("drop_cnt_mid", 32'(drop_cnt), 32'd98);
        chk("overflow_mid", 32'(overflow), 32'd1);
        for (int i = 0; i < 200; i++) tick(1'b1, 1'b0);
        chk("drop_cnt_saturated", 32'(drop_cnt), 32'd255);
        chk("sat_frames", 32'(framesSeen), 32'd0);
        trig = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/reg_trace_tx.md
REG_TRACE_TX -- requirements
Module: reg_trace_tx

Purpose: hardware source of register-file trace frames. It streams a header plus all 32 GPRs over a valid/ready port for the CPU bench and the host logger.

Interface
REQ-001 SHALL have parameter HDR_TAG, default 16'hC10C, constant placed in header bits [31:16].
REQ-002 SHALL have parameter DROP_W, default 8, width of the saturating dropped-trigger counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous reset, active-low.
REQ-005 SHALL have port trig  in  1  dump request, sampled each rising edge.
REQ-006 SHALL have port rf_raddr  out  5  register-file debug read address, registered.
REQ-007 SHALL have port rf_rdata  in  32  combinational read data for rf_raddr.
REQ-008 SHALL have port out_valid  out  1  stream word valid.
REQ-009 SHALL have port out_ready  in  1  sink accepts the word; a handshake occurs when out_valid and out_ready are both 1.
REQ-010 SHALL have port out_data  out  32  stream word.
REQ-011 SHALL have port out_last  out  1  marks the final word (Reg31) of a frame.
REQ-012 SHALL have port overflow  out  1  sticky; a trigger was dropped.
REQ-013 SHALL have port drop_cnt  out  DROP_W  count of dropped triggers, saturating.

Function
REQ-014 SHALL keep a 16-bit free-running cycle counter: 0 at reset release, +1 per clock, wraps 16'hFFFF->0.
REQ-015 SHALL emit 33-word frames: word0 = {HDR_TAG, cycle count at trigger edge}; words 1..32 = Reg0..Reg31 in ascending order.
REQ-016 SHALL implement FSM IDLE, HDR, REG; busy is defined as out_valid==1.
REQ-017 On trig while IDLE, SHALL present the header with out_valid=1 in the next cycle (latency 1) and enter HDR with rf_raddr=0.
REQ-018 In HDR and REG, on each handshake, SHALL register rf_rdata (at the current rf_raddr) into out_data, increment rf_raddr, and set out_last when the loaded address is 31.
REQ-019 SHALL hold out_data, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 On the handshake of the out_last word: with no pending trigger, SHALL drop out_valid and go to IDLE; with a pending trigger, SHALL load the pending header next cycle with no gap, go to HDR, and clear pending.
REQ-021 On trig while busy with no pending trigger, SHALL set pending and capture the current cycle count.
REQ-022 On trig while busy with pending already set, SHALL drop the trigger, set overflow=1, and increment drop_cnt up to 2^DROP_W-1.
REQ-023 On trig in the same cycle as the final handshake with pending set, SHALL consume the old pending trigger and store the new trigger as the new pending one; nothing is dropped.
REQ-024 SHALL read register values live; a frame is not atomic with respect to concurrent writeback.
REQ-025 With out_ready held at 1, SHALL sustain one word per cycle, i.e. one frame per 33 cycles.

Reset
REQ-026 While rst=0, SHALL force: out_valid=0, out_last=0, out_data=0, rf_raddr=0, overflow=0, drop_cnt=0, pending=0, cycle counter=0, state IDLE.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; the sink sees no out_last for that frame.

Structure
REQ-028 SHALL take the state enum, FRAME_WORDS=33 and the default HDR_TAG from shared package trace_pkg.
REQ-029 SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-030 Bench SHALL cover: trig at cycle 5, ready=1, Reg k preloaded with k*0x11111111 -> header 0xC10C0005 at cycle 6, then Reg0..Reg31 on cycles 7..38, out_last only at cycle 38.
REQ-031 Bench SHALL cover: same as REQ-030 with ready toggled 1/0 each cycle -> identical 33-word sequence, data stable through every stall, frame ends at cycle 71.
REQ-032 Bench SHALL cover: trig at 5 and at 10 -> second header 0xC10C000A immediately follows first out_last, back-to-back, overflow=0.
REQ-033 Bench SHALL cover: trig at 5, 10 and 12 -> the trigger at 12 is dropped, overflow=1, drop_cnt=1, exactly two frames emitted.
REQ-034 Bench SHALL cover: rst pulled low during word 20 of a frame -> all outputs 0 asynchronously; next trig after release yields a header whose count restarts from 0.
REQ-035 Bench SHALL cover: trig in the same cycle as the final handshake with pending set -> pending stays set, next header carries the pending cycle, third frame follows, drop_cnt unchanged.
